// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the 4-digit multiplexed display.
//   NUM_DIGITS    number of scanned digits
//   BCD_W         width of one BCD digit
//   BCD_BLANK     code driven on bcd_out for an invalid (>9) digit
//   digits_t      packed array of NUM_DIGITS BCD digits, [0] = rightmost
//   digit_idx_t   scan index type
package disp_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BCD_W      = 4;

   localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
   localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;

   typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digits_t;
   typedef logic [$clog2(NUM_DIGITS)-1:0]    digit_idx_t;

   // Active-low one-hot anode pattern for the given digit slot.
   function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input digit_idx_t idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/disp_prescaler.sv
// disp_prescaler: free-running modulo-DIV counter.
//   clk    system clock, rising edge
//   rst    synchronous active-high reset, clears the count
//   o_tick one-cycle pulse while the count equals DIV-1
module disp_prescaler #(
   parameter int unsigned DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic o_tick
);

   localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_count;
   logic          w_last;

   assign w_last = (r_count == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tick = w_last;

endmodule

// File: rtl/disp_mux4.sv
// disp_mux4: time-multiplexed driver for a 4-digit BCD display with shadow
// register, frame-synchronous commit and leading-zero blanking.
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   load         strobe, captures digits_in/dp_in into the shadow register
//   digits_in    four BCD digits, [3:0] = digit0 (rightmost)
//   dp_in        decimal point request per digit, active-high
//   blank_lz     runtime leading-zero blanking enable
//   bcd_out      BCD code of the scanned digit (4'hF for an invalid digit)
//   an           anode enables, active-low, at most one low
//   dp_out       decimal point of the scanned digit, active-low
//   frame_start  one-cycle pulse when the scan index returns to digit0
//   pending      shadow holds data not yet committed to the active register
module disp_mux4
   import disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned LZ_BLANK_EN = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [15:0]           digits_in,
   input  logic [NUM_DIGITS-1:0] dp_in,
   input  logic                  blank_lz,
   output logic [BCD_W-1:0]      bcd_out,
   output logic [NUM_DIGITS-1:0] an,
   output logic                  dp_out,
   output logic                  frame_start,
   output logic                  pending
);

   logic w_tick;

   disp_prescaler #(
      .DIV (REFRESH_DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .o_tick (w_tick)
   );

   digits_t               r_shadow;
   digits_t               r_active;
   logic [NUM_DIGITS-1:0] r_shadow_dp;
   logic [NUM_DIGITS-1:0] r_active_dp;
   logic                  r_pending;
   digit_idx_t            r_idx;
   logic [NUM_DIGITS-1:0] r_an;
   logic [BCD_W-1:0]      r_bcd;
   logic                  r_dp;
   logic                  r_frame;

   logic                  w_lz_en;
   logic                  w_wrap;
   logic [BCD_W-1:0]      w_digit;
   logic                  w_invalid;
   logic [NUM_DIGITS-1:0] w_lz_blank;
   logic                  w_blank;
   logic [NUM_DIGITS-1:0] w_an_next;
   logic [BCD_W-1:0]      w_bcd_next;
   logic                  w_dp_next;

   assign w_lz_en = (LZ_BLANK_EN != 0) && blank_lz;
   assign w_wrap  = w_tick && (r_idx == digit_idx_t'(NUM_DIGITS - 1));

   // r_idx names the slot that the next tick puts on the display; after reset
   // the outputs stay dark and the first tick lights digit0. The tick that
   // shows digit3 moves the index back to 0, which is where shadow commits.
   always_comb begin
      w_digit   = r_active[r_idx];
      w_invalid = (w_digit > BCD_MAX);

      // A slot is a leading zero only if it and every higher slot are zero
      // with no decimal point; digit0 is always shown.
      w_lz_blank    = '0;
      w_lz_blank[3] = w_lz_en && (r_active[3] == '0) && !r_active_dp[3];
      w_lz_blank[2] = w_lz_blank[3] && (r_active[2] == '0) && !r_active_dp[2];
      w_lz_blank[1] = w_lz_blank[2] && (r_active[1] == '0) && !r_active_dp[1];

      w_blank    = w_invalid || w_lz_blank[r_idx];
      w_an_next  = w_blank ? '1 : an_onehot_low(r_idx);
      w_dp_next  = w_blank ? 1'b1 : ~r_active_dp[r_idx];
      w_bcd_next = w_invalid ? BCD_BLANK : w_digit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shadow    <= '0;
         r_active    <= '0;
         r_shadow_dp <= '0;
         r_active_dp <= '0;
         r_pending   <= 1'b0;
         r_idx       <= '0;
         r_an        <= '1;
         r_bcd       <= '0;
         r_dp        <= 1'b1;
         r_frame     <= 1'b0;
      end else begin
         r_frame <= w_wrap;

         if (w_tick) begin
            r_idx <= r_idx + digit_idx_t'(1);
            r_an  <= w_an_next;
            r_bcd <= w_bcd_next;
            r_dp  <= w_dp_next;
         end

         // Commit takes the pre-edge shadow, so a load on the wrap tick is
         // held back for the following frame.
         if (w_wrap) begin
            r_active    <= r_shadow;
            r_active_dp <= r_shadow_dp;
         end

         if (load) begin
            r_shadow    <= digits_in;
            r_shadow_dp <= dp_in;
            r_pending   <= 1'b1;
         end else if (w_wrap) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Reset forces the display dark in the very cycle it is asserted, ahead
   // of the registers being cleared on the next edge.
   assign an          = rst ? '1   : r_an;
   assign dp_out      = rst ? 1'b1 : r_dp;
   assign bcd_out     = rst ? '0   : r_bcd;
   assign frame_start = r_frame & ~rst;
   assign pending     = r_pending;

endmodule

// File: doc/disp_mux4.md
DISP_MUX4 -- requirements
Module: disp_mux4

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20.
REQ-002 Parameter LZ_BLANK_EN, default 1, meaning 1 enables leading-zero blanking logic; 0 ties blanking off.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; captures digits_in/dp_in into the shadow register.
REQ-006 digits_in  input  16  four BCD digits; [3:0]=digit0 (rightmost) ... [15:12]=digit3.
REQ-007 dp_in  input  4  decimal point request per digit, bit i = digit i, active-high.
REQ-008 blank_lz  input  1  runtime leading-zero blanking enable (effective only when LZ_BLANK_EN=1).
REQ-009 bcd_out  output  4  BCD code of the currently scanned digit, fed to the downstream bcd2sseg decoder.
REQ-010 an  output  4  digit anode enables, active-low, one-hot-low or all-high.
REQ-011 dp_out  output  1  decimal point for the scanned digit, active-low.
REQ-012 frame_start  output  1  one-cycle pulse when the scan returns to digit0.
REQ-013 pending  output  1  high while a loaded value waits in shadow and is not yet displayed.

Function
REQ-014 Prescaler counts 0..REFRESH_DIV-1 and wraps; tick asserted for one cycle when count = REFRESH_DIV-1.
REQ-015 Digit index (2 bits) advances 0->1->2->3->0 on each tick; no other transition.
REQ-016 Outputs bcd_out, an, dp_out are registered and change exactly one cycle after the tick that moves the index.
REQ-017 load captures digits_in/dp_in into shadow in the cycle it is high and sets pending next cycle.
REQ-018 Shadow copies to the active register on the tick that wraps index 3->0; pending clears in that same update; frame_start pulses in the same cycle as that update.
REQ-019 load coincident with the wrap tick: the new data is captured to shadow and pending stays high; the previous shadow content is committed to active.
REQ-020 Multiple loads within one frame: last one wins; only one commit occurs per frame.
REQ-021 Digit with value > 9 is invalid: its anode stays high (blanked) and bcd_out = 4'hF.
REQ-022 Leading-zero blanking (blank_lz=1, LZ_BLANK_EN=1): digits 3, 2, 1 are blanked when they and all higher digits are zero; digit0 is never blanked by this rule.
REQ-023 A digit with dp requested is not blanked by the leading-zero rule, and digits below it are not blanked either.
REQ-024 Blanked digit: an bit high, dp_out high, bcd_out still carries the digit code (except under REQ-021).
REQ-025 At most one an bit is low in any cycle.

Reset
REQ-026 rst clears the prescaler, index, shadow, active register and pending to 0.
REQ-027 During and one cycle after rst: an = 4'hF, dp_out = 1, bcd_out = 0, frame_start = 0.
REQ-028 Reset asserted mid-frame discards the shadow and the active data; scanning restarts at digit0 after a full REFRESH_DIV period.
REQ-029 load coincident with rst is ignored.

Structure
REQ-030 Shared package disp_pkg holds NUM_DIGITS=4, BCD_W=4, the BCD_BLANK=4'hF constant and the typedef for the digit array (4 x 4-bit).
REQ-031 Sub-module disp_prescaler (parameterised counter producing tick) is instantiated once; the remaining logic resides in disp_mux4.
REQ-032 bcd_out connects directly to the 4-bit BCD inputs of the bcd2sseg decoder, with no additional logic between them.

Verification (REFRESH_DIV=4 in the bench)
REQ-033 rst for 3 cycles, then release -> an=4'hF until the first tick; then an cycles E,D,B,7 every 4 clks; frame_start every 16 clks.
REQ-034 load digits_in=16'h1234 mid-frame -> pending=1; at the next wrap, bcd_out sequence 4,3,2,1 with an E,D,B,7; pending=0.
REQ-035 blank_lz=1, load 16'h0007, dp_in=0 -> only an=E is active (bcd 7); with dp_in=4'b0100, digits 2,1,0 are lit (bcd 0,0,7).
REQ-036 load 16'h9A05 -> the digit2 slot shows an=F and bcd_out=F; the other slots display normally.
REQ-037 Two loads (16'h1111, then 16'h2222) within one frame, and a load on the wrap tick -> 16'h2222 is shown for one frame, then the wrap-tick value.
REQ-038 rst asserted during the digit2 slot -> next cycle an=F, pending=0; after release, scanning restarts at digit0 showing 0.
